mem_node_arbiter: RTL and testbench

Round-robin OBI arbiter that shares one memory-side OBI master port among NUM_MASTERS CGRA memory nodes (input and output memory nodes). Each granted request's master index is tracked in an in-order ID queue so responses return to the right node. Sits between the memory-node array and the system bus crossbar, one instance per bus port.

---
 rtl/mem_node_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_node_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_node_arbiter.sv
// Round-robin OBI arbiter: one bus-side master port shared by NUM_MASTERS memory nodes.
// Granted master indices are queued so in-order responses reach the node that issued them.
package mem_node_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module mem_node_arbiter
  import mem_node_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clr_i,
  input  obi_req_t  masters_req_i  [NUM_MASTERS],
  output obi_resp_t masters_resp_o [NUM_MASTERS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] r_ptr;
  logic             r_lock_v;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_ids [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [IDX_W-1:0] w_rot_idx [NUM_MASTERS];
  logic [IDX_W-1:0] w_sel;
  logic             w_sel_v;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_txn;
  logic             w_pop;
  logic             w_spurious;

  // Candidate index for each priority slot, starting at r_ptr and wrapping mod NUM_MASTERS.
  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_rot
    logic [IDX_W:0] w_sum;
    assign w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
    assign w_rot_idx[k] = (w_sum >= (IDX_W+1)'(NUM_MASTERS))
                        ? IDX_W'(w_sum - (IDX_W+1)'(NUM_MASTERS))
                        : w_sum[IDX_W-1:0];
  end

  // Scanning slots high to low lets the lowest-priority-offset requester win the last write.
  always_comb begin
    w_sel_v = 1'b0;
    w_sel   = '0;
    if (r_lock_v) begin
      w_sel_v = 1'b1;
      w_sel   = r_lock_idx;
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        if (masters_req_i[w_rot_idx[k]].req) begin
          w_sel_v = 1'b1;
          w_sel   = w_rot_idx[k];
        end
      end
    end
  end

  assign w_full     = (r_cnt == CNT_W'(MAX_OUTSTANDING));
  assign w_empty    = (r_cnt == '0);
  assign w_head     = r_ids[r_rptr];
  assign w_txn      = slave_req_o.req & slave_resp_i.gnt;
  assign w_pop      = slave_resp_i.rvalid & ~w_empty;
  assign w_spurious = slave_resp_i.rvalid & w_empty;
  assign w_ptr_nxt  = (w_sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_sel + IDX_W'(1);

  always_comb begin
    slave_req_o = '0;
    if (w_sel_v) begin
      slave_req_o     = masters_req_i[w_sel];
      slave_req_o.req = ~w_full;
    end
  end

  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      masters_resp_o[m].gnt    = w_txn & (w_sel == IDX_W'(m));
      masters_resp_o[m].rvalid = w_pop & (w_head == IDX_W'(m));
      masters_resp_o[m].rdata  = slave_resp_i.rdata;
    end
  end

  assign busy_o = ~w_empty;
  assign err_o  = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_lock_v   <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      for (int q = 0; q < MAX_OUTSTANDING; q++) r_ids[q] <= '0;
    end else if (clr_i) begin
      r_ptr      <= '0;
      r_lock_v   <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      // A request left ungranted must stay on the bus unchanged until accepted.
      if (w_txn) begin
        r_ptr    <= w_ptr_nxt;
        r_lock_v <= 1'b0;
      end else if (slave_req_o.req) begin
        r_lock_v   <= 1'b1;
        r_lock_idx <= w_sel;
      end

      if (w_txn) begin
        r_ids[r_wptr] <= w_sel;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);

      case ({w_txn, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_spurious) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_node_arbiter.sv
// Bench for mem_node_arbiter: directed vector table for the documented scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_mem_node_arbiter;
  import mem_node_arbiter_pkg::*;

  localparam int NM = 4;
  localparam int MO = 4;

  logic      clk_i = 1'b0;
  logic      rst_i;
  logic      clr_i;
  obi_req_t  masters_req_i  [NM];
  obi_resp_t masters_resp_o [NM];
  obi_req_t  slave_req_o;
  obi_resp_t slave_resp_i;
  logic      busy_o;
  logic      err_o;

  mem_node_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(MO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .masters_req_i  (masters_req_i),
    .masters_resp_o (masters_resp_o),
    .slave_req_o    (slave_req_o),
    .slave_resp_i   (slave_resp_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        clr;
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    int          exp_sel;
    logic        exp_req;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_addr [NM];
  vec_t        vt [$];
  obi_req_t    cur [NM];

  // reference model state
  int ptr;
  bit lk;
  int lki;
  int idq [$];
  bit merr;

  function automatic vec_t mk(string name, logic clr, logic [3:0] req, logic gnt, logic rv,
                              logic [31:0] rdata, int esel, logic ereq, logic [3:0] egnt,
                              logic [3:0] erv, logic ebusy, logic eerr);
    vec_t v;
    v.name = name; v.clr = clr; v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.exp_sel = esel; v.exp_req = ereq; v.exp_gnt = egnt; v.exp_rv = erv;
    v.exp_busy = ebusy; v.exp_err = eerr;
    return v;
  endfunction

  task automatic drive_dir(logic clr, logic [3:0] req, logic gnt, logic rv, logic [31:0] rdata);
    clr_i = clr;
    for (int i = 0; i < NM; i++) begin
      cur[i].req   = req[i];
      cur[i].we    = (i % 2) == 1;
      cur[i].be    = 4'hF;
      cur[i].addr  = m_addr[i];
      cur[i].wdata = m_addr[i] ^ 32'hA5A5_0000;
      masters_req_i[i] = cur[i];
    end
    slave_resp_i.gnt    = gnt;
    slave_resp_i.rvalid = rv;
    slave_resp_i.rdata  = rdata;
  endtask

  task automatic check(string name, obi_req_t e_req, logic [NM-1:0] e_gnt, logic [NM-1:0] e_rv,
                       logic [31:0] e_rdata, logic e_busy, logic e_err);
    logic [NM-1:0] a_gnt;
    logic [NM-1:0] a_rv;
    bit            rd_ok;
    rd_ok = 1'b1;
    for (int m = 0; m < NM; m++) begin
      a_gnt[m] = masters_resp_o[m].gnt;
      a_rv[m]  = masters_resp_o[m].rvalid;
      if (masters_resp_o[m].rdata !== e_rdata) rd_ok = 1'b0;
    end
    n_vec++;
    if (slave_req_o !== e_req || a_gnt !== e_gnt || a_rv !== e_rv || !rd_ok ||
        busy_o !== e_busy || err_o !== e_err) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%h we=%0b be=%h wdata=%h gnt=%b rvalid=%b rdata_ok=%0b busy=%0b err=%0b | expected req=%0b addr=%h we=%0b be=%h wdata=%h gnt=%b rvalid=%b busy=%0b err=%0b",
               name, slave_req_o.req, slave_req_o.addr, slave_req_o.we, slave_req_o.be,
               slave_req_o.wdata, a_gnt, a_rv, rd_ok, busy_o, err_o,
               e_req.req, e_req.addr, e_req.we, e_req.be, e_req.wdata, e_gnt, e_rv, e_busy, e_err);
    end
  endtask

  initial begin
    obi_req_t e;
    m_addr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'h0000_0300};

    vt.push_back(mk("single_req",     0, 4'b0100, 1, 0, 32'h0,    2, 1, 4'b0100, 4'b0000, 0, 0));
    vt.push_back(mk("single_wait1",   0, 4'b0000, 1, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("single_wait2",   0, 4'b0000, 1, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("single_rvalid",  0, 4'b0000, 0, 1, 32'hCAFE,-1, 0, 4'b0000, 4'b0100, 1, 0));
    vt.push_back(mk("single_idle",    0, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("clr_before_rr",  1, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("rr_g0",          0, 4'b1011, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 0, 0));
    vt.push_back(mk("rr_g1",          0, 4'b1011, 1, 1, 32'h100,  1, 1, 4'b0010, 4'b0001, 1, 0));
    vt.push_back(mk("rr_g3",          0, 4'b1011, 1, 1, 32'h101,  3, 1, 4'b1000, 4'b0010, 1, 0));
    vt.push_back(mk("rr_g0_wrap",     0, 4'b1011, 1, 1, 32'h102,  0, 1, 4'b0001, 4'b1000, 1, 0));
    vt.push_back(mk("rr_g1b",         0, 4'b1011, 1, 1, 32'h103,  1, 1, 4'b0010, 4'b0001, 1, 0));
    vt.push_back(mk("rr_g3b",         0, 4'b1011, 1, 1, 32'h104,  3, 1, 4'b1000, 4'b0010, 1, 0));
    vt.push_back(mk("rr_drain",       0, 4'b0000, 0, 1, 32'h105, -1, 0, 4'b0000, 4'b1000, 1, 0));
    for (int c = 0; c < 5; c++)
      vt.push_back(mk("lock_hold",    0, 4'b0011, 0, 0, 32'h0,    0, 1, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("lock_release",   0, 4'b0011, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 0, 0));
    vt.push_back(mk("after_lock_m1",  0, 4'b0011, 1, 0, 32'h0,    1, 1, 4'b0010, 4'b0000, 1, 0));
    vt.push_back(mk("lock_m0",        0, 4'b0001, 0, 0, 32'h0,    0, 1, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("lock_beats_m3",  0, 4'b1001, 0, 0, 32'h0,    0, 1, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("lock_gnt",       0, 4'b1001, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 1, 0));
    vt.push_back(mk("fill_m3",        0, 4'b1001, 1, 0, 32'h0,    3, 1, 4'b1000, 4'b0000, 1, 0));
    vt.push_back(mk("full_block",     0, 4'b1001, 1, 0, 32'h0,    0, 0, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("full_pop",       0, 4'b1001, 1, 1, 32'h11,   0, 0, 4'b0000, 4'b0001, 1, 0));
    vt.push_back(mk("refill",         0, 4'b1001, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 1, 0));
    vt.push_back(mk("drain_m1",       0, 4'b0000, 0, 1, 32'h21,  -1, 0, 4'b0000, 4'b0010, 1, 0));
    vt.push_back(mk("drain_m0",       0, 4'b0000, 0, 1, 32'h22,  -1, 0, 4'b0000, 4'b0001, 1, 0));
    vt.push_back(mk("drain_m3",       0, 4'b0000, 0, 1, 32'h23,  -1, 0, 4'b0000, 4'b1000, 1, 0));
    vt.push_back(mk("drain_m0b",      0, 4'b0000, 0, 1, 32'h24,  -1, 0, 4'b0000, 4'b0001, 1, 0));
    vt.push_back(mk("spurious",       0, 4'b0000, 0, 1, 32'h31,  -1, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("err_sticky",     0, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 1));
    vt.push_back(mk("err_clr",        1, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 1));
    vt.push_back(mk("err_cleared",    0, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("mf_g2",          0, 4'b0100, 1, 0, 32'h0,    2, 1, 4'b0100, 4'b0000, 0, 0));
    vt.push_back(mk("mf_g0",          0, 4'b0001, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 1, 0));
    vt.push_back(mk("mf_clr",         1, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 1, 0));
    vt.push_back(mk("mf_ptr0_drop",   0, 4'b0101, 0, 1, 32'h41,   0, 1, 4'b0000, 4'b0000, 0, 0));
    vt.push_back(mk("mf_err",         0, 4'b0101, 1, 0, 32'h0,    0, 1, 4'b0001, 4'b0000, 0, 1));
    vt.push_back(mk("mf_rv",          0, 4'b0000, 0, 1, 32'h42,  -1, 0, 4'b0000, 4'b0001, 1, 1));
    vt.push_back(mk("final_clr",      1, 4'b0000, 0, 0, 32'h0,   -1, 0, 4'b0000, 4'b0000, 0, 1));

    rst_i = 1'b1;
    drive_dir(1'b0, 4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF);
    #2;
    check("reset_state", '0, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    foreach (vt[k]) begin
      drive_dir(vt[k].clr, vt[k].req, vt[k].gnt, vt[k].rv, vt[k].rdata);
      #1;
      e = '0;
      if (vt[k].exp_sel >= 0) e = cur[vt[k].exp_sel];
      e.req = vt[k].exp_req;
      check(vt[k].name, e, vt[k].exp_gnt, vt[k].exp_rv, vt[k].rdata, vt[k].exp_busy, vt[k].exp_err);
      @(posedge clk_i); #1;
    end

    // Randomized traffic against the model; the bench starts from the cleared state above.
    ptr = 0; lk = 0; lki = 0; idq.delete(); merr = 0;
    for (int i = 0; i < NM; i++) cur[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      int            sel;
      bit            full;
      bit            txn;
      logic [NM-1:0] e_gnt;
      logic [NM-1:0] e_rv;
      clr_i = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NM; i++) begin
        if (lk && i == lki) begin
          cur[i].req = 1'b1;
        end else begin
          cur[i].req   = ($urandom_range(0, 2) != 0);
          cur[i].we    = 1'($urandom);
          cur[i].be    = 4'($urandom);
          cur[i].addr  = $urandom;
          cur[i].wdata = $urandom;
        end
        masters_req_i[i] = cur[i];
      end
      slave_resp_i.gnt    = 1'($urandom);
      slave_resp_i.rvalid = (idq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 31) == 0);
      slave_resp_i.rdata  = $urandom;
      #1;

      sel = -1;
      if (lk) sel = lki;
      else
        for (int k = 0; k < NM; k++)
          if (sel < 0 && cur[(ptr + k) % NM].req) sel = (ptr + k) % NM;
      full = (idq.size() == MO);
      e = '0;
      if (sel >= 0) begin
        e = cur[sel];
        e.req = !full;
      end
      txn   = e.req && slave_resp_i.gnt;
      e_gnt = txn ? 4'(1 << sel) : 4'b0;
      e_rv  = (slave_resp_i.rvalid && idq.size() > 0) ? 4'(1 << idq[0]) : 4'b0;
      check("random", e, e_gnt, e_rv, slave_resp_i.rdata, idq.size() > 0, merr);

      if (clr_i) begin
        ptr = 0; lk = 0; idq.delete(); merr = 0;
      end else begin
        if (slave_resp_i.rvalid) begin
          if (idq.size() > 0) void'(idq.pop_front());
          else merr = 1;
        end
        if (txn) begin
          idq.push_back(sel);
          ptr = (sel + 1) % NM;
          lk  = 0;
        end else if (e.req) begin
          lk  = 1;
          lki = sel;
        end
      end
      @(posedge clk_i); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
